// File: rtl/seq_divider_8by4_pkg.sv
// Shared types and constants for the 8-by-4 sequential restoring divider.
package seq_divider_8by4_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;
    localparam int DEF_CNT_W      = 4;

    // Quotient reported when the divisor is zero: all ones.
    localparam logic [DEF_DIVIDEND_W-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface seq_divider_8by4_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    // Requester side: issues operands, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8by4_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not go negative.
module seq_divider_8by4_div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] p_i,      // partial remainder, always < divisor
    input  logic                 q_msb_i,  // next dividend bit shifted in
    input  logic [DIVISOR_W-1:0] d_i,      // divisor
    output logic [DIVISOR_W-1:0] p_o,      // next partial remainder
    output logic                 q_bit_o   // quotient bit retired this step
);

    logic [DIVISOR_W:0] t;

    // Compare/subtract at DIVISOR_W+1 bits; when T >= D the result is < D, so
    // the low DIVISOR_W bits of the difference hold it exactly.
    always_comb begin
        t       = {p_i, q_msb_i};
        q_bit_o = (t >= {1'b0, d_i});
        p_o     = q_bit_o ? (t[DIVISOR_W-1:0] - d_i) : t[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/seq_divider_8by4.sv
// 8-bit by 4-bit sequential restoring divider, one quotient bit per clock,
// behind a start/done handshake. Divide by zero answers in one cycle with an
// all-ones quotient and the div_by_zero flag.
module seq_divider_8by4
    import seq_divider_8by4_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic             clk,
    input logic             rst,
    seq_divider_8by4_if.slave bus
);

    // Working registers. The partial remainder is kept DIVISOR_W bits wide:
    // after every step it is below the divisor, so the extra bit of the
    // DIVISOR_W+1 trial value only exists inside the step logic.
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W-1:0]  p_q, p_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;

    // Registered outputs.
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  div0_q, div0_d;

    logic [DIVISOR_W-1:0]  step_p;
    logic                  step_qbit;
    logic [DIVIDEND_W-1:0] q_shifted;

    seq_divider_8by4_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .p_i     (p_q),
        .q_msb_i (q_q[DIVIDEND_W-1]),
        .d_i     (d_q),
        .p_o     (step_p),
        .q_bit_o (step_qbit)
    );

    assign q_shifted = {q_q[DIVIDEND_W-2:0], step_qbit};

    // Next-state and datapath update: accept starts in IDLE/DONE, iterate in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        d_d         = d_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div0_d      = div0_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    q_d    = bus.dividend;
                    p_d    = '0;
                    d_d    = bus.divisor;
                    cnt_d  = '0;
                    div0_d = 1'b0;
                    if (bus.divisor == '0) begin
                        // No iterations: answer immediately.
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = DIV0_QUOTIENT;
                        remainder_d = '0;
                        div0_d      = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                // start is deliberately not looked at here.
                p_d   = step_p;
                q_d   = q_shifted;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = q_shifted;
                    remainder_d = step_p;
                end else begin
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register for FSM, datapath and outputs; reset abandons any
    // operation in flight and clears all results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div0_q      <= div0_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div0_q;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Testbench for seq_divider_8by4: directed handshake/timing scenarios, an
// exhaustive sweep, multiplier round trip and random operations against an
// arithmetic reference model.
module tb_seq_divider_8by4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;

    seq_divider_8by4_if bus ();

    seq_divider_8by4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, divide by zero gives all ones / 0 / flag.
    task automatic check_res(input string tag, input logic [7:0] a, input logic [3:0] b);
        int eq, er, ez;
        if (b == 0) begin
            eq = 255; er = 0; ez = 1;
        end else begin
            eq = int'(a) / int'(b); er = int'(a) % int'(b); ez = 0;
        end
        check({tag, ".quotient"},  32'(bus.quotient),    32'(eq));
        check({tag, ".remainder"}, 32'(bus.remainder),   32'(er));
        check({tag, ".div0"},      32'(bus.div_by_zero), 32'(ez));
    endtask

    // Present operands with start for exactly one cycle; sc = start cycle.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b, output int sc);
        sc           = cyc;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    // Bounded wait for done; returns cycles elapsed since the start cycle.
    task automatic wait_done(input int sc, output int lat);
        while (!bus.done && (cyc - sc) < 20) tick();
        lat = cyc - sc;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b);
        int sc, lat;
        start_op(a, b, sc);
        wait_done(sc, lat);
        check({tag, ".latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'd9);
        check_res(tag, a, b);
    endtask

    initial begin
        int sc, lat, k;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.done", 32'(bus.done), 0);
        check_res("rst", 8'd0, 4'd1);

        // Reset wins over start in the same cycle
        bus.start = 1'b1; bus.dividend = 8'd5; bus.divisor = 4'd1;
        tick();
        bus.start = 1'b0;
        rst = 1'b0;
        check("rst_vs_start.busy", 32'(bus.busy), 0);
        tick();
        check("rst_vs_start.busy2", 32'(bus.busy), 0);
        check("rst_vs_start.done", 32'(bus.done), 0);
        tick();

        // 200 / 7 with cycle-accurate busy/done
        start_op(8'd200, 4'd7, sc);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t200_7.busy_c%0d", c), 32'(bus.busy), 1);
            check($sformatf("t200_7.done_c%0d", c), 32'(bus.done), 0);
            tick();
        end
        check("t200_7.done_c9", 32'(bus.done), 1);
        check("t200_7.busy_c9", 32'(bus.busy), 0);
        check_res("t200_7", 8'd200, 4'd7);
        tick();
        check("t200_7.done_c10", 32'(bus.done), 0);
        check("t200_7.busy_c10", 32'(bus.busy), 0);

        // Directed values, results held in IDLE
        run_op("t255_15", 8'd255, 4'd15);
        tick(); tick(); tick();
        check("hold.done", 32'(bus.done), 0);
        check_res("hold", 8'd255, 4'd15);
        run_op("t5_9", 8'd5, 4'd9);
        tick();
        run_op("t0_1", 8'd0, 4'd1);
        tick();

        // Divide by zero, then recovery
        run_op("t77_0", 8'd77, 4'd0);
        tick();
        run_op("t10_3", 8'd10, 4'd3);
        tick();

        // Start while busy ignored; back-to-back start in the done cycle
        start_op(8'd100, 4'd3, sc);
        tick(); tick(); tick();
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd2;
        tick();
        bus.start = 1'b0;
        wait_done(sc, lat);
        check("busy_ign.latency", 32'(lat), 9);
        check_res("busy_ign", 8'd100, 4'd3);
        start_op(8'd9, 4'd2, k);
        check("b2b.done_drop", 32'(bus.done), 0);
        check("b2b.busy", 32'(bus.busy), 1);
        wait_done(sc, lat);
        check("b2b.latency", 32'(lat), 18);
        check_res("b2b", 8'd9, 4'd2);
        tick();

        // Reset mid-run abandons the operation
        start_op(8'd200, 4'd7, sc);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", 32'(bus.busy), 0);
        check("midrst.done", 32'(bus.done), 0);
        check_res("midrst", 8'd0, 4'd1);
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) k++;
            tick();
        end
        check("midrst.no_done", 32'(k), 0);
        run_op("t6_6", 8'd6, 4'd6);

        // Exhaustive sweep, back-to-back (each start issued in the previous done cycle)
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op($sformatf("sweep_%0d_%0d", a, b), 8'(a), 4'(b));
            end
        end
        tick();

        // Multiplier round trip: (a*b) / b must give back a with remainder 0
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                start_op(8'(a * b), 4'(b), sc);
                wait_done(sc, lat);
                check($sformatf("rt_%0dx%0d.quotient", a, b), 32'(bus.quotient), 32'(a));
                check($sformatf("rt_%0dx%0d.remainder", a, b), 32'(bus.remainder), 0);
            end
        end
        tick();

        // Random operations with stray start pulses while busy
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra;
            logic [3:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            start_op(ra, rb, sc);
            if (rb != 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 4);
                for (int j = 0; j < k; j++) tick();
                bus.start    = 1'b1;
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
                tick();
                bus.start    = 1'b0;
            end
            wait_done(sc, lat);
            check($sformatf("rand%0d.latency", i), 32'(lat), (rb == 0) ? 32'd1 : 32'd9);
            check_res($sformatf("rand%0d", i), ra, rb);
            for (int j = 0; j < $urandom_range(0, 2); j++) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
